// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then clocks out
// one byte on device-generated falling edges and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES   = 5000,
    parameter int RTS_SETUP_CYCLES = 20,
    parameter int START_TIMEOUT    = 750000,
    parameter int PACKET_TIMEOUT   = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] err_code
);

    localparam int M1   = (INHIBIT_CYCLES > RTS_SETUP_CYCLES) ? INHIBIT_CYCLES : RTS_SETUP_CYCLES;
    localparam int M2   = (START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT : PACKET_TIMEOUT;
    localparam int TMAX = (M1 > M2) ? M1 : M2;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] INH_END = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] RTS_END = TW'(RTS_SETUP_CYCLES - 1);
    localparam logic [TW-1:0] ST_END  = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] PK_END  = TW'(PACKET_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, WAIT_FIRST, SEND, WAIT_ACK, WAIT_IDLE
    } state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   timer;
    logic [3:0]      bitcount;
    logic [9:0]      sh;
    logic            dat_low;
    logic            clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic            fe;
    logic [1:0]      err_nx;
    logic            done_nx;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk_in;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat_in;
            dat_s2   <= dat_s1;
        end
    end

    assign fe = clk_prev & ~clk_s2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // A falling edge always takes precedence over a timeout in the same cycle.
    always_comb begin
        state_nx = state;
        err_nx   = 2'b00;
        done_nx  = 1'b0;
        unique case (state)
            IDLE:       if (tx_valid) state_nx = INHIBIT;
            INHIBIT:    if (timer == INH_END) state_nx = RTS;
            RTS:        if (timer == RTS_END) state_nx = WAIT_FIRST;
            WAIT_FIRST: begin
                if (fe) state_nx = SEND;
                else if (timer == ST_END) begin
                    state_nx = IDLE;
                    err_nx   = 2'b01;
                end
            end
            SEND: begin
                if (fe) begin
                    if (bitcount == 4'd9) state_nx = WAIT_ACK;
                end else if (timer == PK_END) begin
                    state_nx = IDLE;
                    err_nx   = 2'b10;
                end
            end
            WAIT_ACK: begin
                if (fe) begin
                    if (!dat_s2) state_nx = WAIT_IDLE;
                    else begin
                        state_nx = IDLE;
                        err_nx   = 2'b11;
                    end
                end else if (timer == PK_END) begin
                    state_nx = IDLE;
                    err_nx   = 2'b10;
                end
            end
            WAIT_IDLE: begin
                if (clk_s2 && dat_s2) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else if (timer == PK_END) begin
                    state_nx = IDLE;
                    err_nx   = 2'b10;
                end
            end
            default:    state_nx = IDLE;
        endcase
    end

    // Packet timer keeps running from SEND through WAIT_ACK and WAIT_IDLE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer    <= '0;
            bitcount <= '0;
            sh       <= '0;
            dat_low  <= 1'b0;
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            err_code <= 2'b00;
        end else begin
            tx_done  <= done_nx;
            tx_error <= |err_nx;
            if (|err_nx) err_code <= err_nx;
            if (state == IDLE) timer <= '0;
            else if (state_nx != state && state_nx != WAIT_ACK && state_nx != WAIT_IDLE)
                timer <= '0;
            else
                timer <= timer + 1'b1;
            if (state == IDLE && tx_valid) begin
                sh       <= {1'b1, ~^tx_data, tx_data};
                bitcount <= '0;
                dat_low  <= 1'b0;
                err_code <= 2'b00;
            end else if (fe && (state == WAIT_FIRST || state == SEND)) begin
                dat_low  <= ~sh[0];
                sh       <= {1'b0, sh[9:1]};
                bitcount <= (state == WAIT_FIRST) ? 4'd1 : bitcount + 4'd1;
            end
        end
    end

    always_comb begin
        tx_ready   = (state == IDLE);
        rx_inhibit = (state != IDLE);
        ps2_clk_oe = (state == INHIBIT) || (state == RTS);
        ps2_dat_oe = 1'b0;
        unique case (state)
            RTS, WAIT_FIRST: ps2_dat_oe = 1'b1;
            SEND, WAIT_ACK:  ps2_dat_oe = dat_low;
            default:         ps2_dat_oe = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain line model and a
// simple PS/2 device that clocks frames and optionally ACKs.
module tb_ps2_host_tx;

    localparam int INH  = 5000;
    localparam int RTSC = 20;
    localparam int STO  = 3000;
    localparam int PTO  = 2000;
    localparam int HALF = 20;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk_in, ps2_dat_in;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, ps2_clk_oe, ps2_dat_oe, rx_inhibit, tx_done, tx_error;
    logic [1:0] err_code;
    logic       dev_clk, dev_dat;

    int nvec = 0;
    int nerr = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int fe_cyc = 0;

    ps2_host_tx #(
        .INHIBIT_CYCLES  (INH),
        .RTS_SETUP_CYCLES(RTSC),
        .START_TIMEOUT   (STO),
        .PACKET_TIMEOUT  (PTO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe),
        .rx_inhibit(rx_inhibit),
        .tx_done   (tx_done),
        .tx_error  (tx_error),
        .err_code  (err_code)
    );

    always #10 clock = ~clock;

    assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
    assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (tx_done)  done_cnt <= done_cnt + 1;
        if (tx_error) err_cnt  <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept a byte, then measure the inhibit and request-to-send phases.
    task automatic start_tx(input logic [7:0] b, input bit inject,
                            output int n_inh, output int n_rts);
        @(negedge clock);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clock);
        tx_valid = 1'b0;
        chk("ready_low", tx_ready, 0);
        chk("rx_inhibit", rx_inhibit, 1);
        n_inh = 0;
        while (ps2_clk_oe && !ps2_dat_oe && n_inh < 20000) begin
            if (inject && n_inh == 100) begin
                tx_data  = 8'hAA;
                tx_valid = 1'b1;
            end
            if (inject && n_inh == 104) tx_valid = 1'b0;
            n_inh++;
            @(negedge clock);
        end
        n_rts = 0;
        while (ps2_clk_oe && ps2_dat_oe && n_rts < 20000) begin
            n_rts++;
            @(negedge clock);
        end
    endtask

    task automatic dev_run(input int nclk, input bit ack, output logic [10:0] fr);
        int w;
        fr = '1;
        w = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && w < 20000) begin
            @(negedge clock);
            w++;
        end
        fr[0] = ps2_dat_in;
        for (int i = 1; i <= nclk; i++) begin
            if (i == 11 && ack) dev_dat = 1'b0;
            repeat (HALF) @(negedge clock);
            dev_clk = 1'b0;
            if (i == 1) fe_cyc = cyc;
            repeat (HALF) @(negedge clock);
            if (i <= 10) fr[i] = ps2_dat_in;
            dev_clk = 1'b1;
        end
        repeat (HALF) @(negedge clock);
        dev_dat = 1'b1;
    endtask

    task automatic wait_idle;
        int w;
        w = 0;
        while (!tx_ready && w < 5000) begin
            @(negedge clock);
            w++;
        end
        repeat (3) @(negedge clock);
        chk("back_idle", tx_ready, 1);
    endtask

    initial begin
        int n_inh, n_rts, m, d0, e0;
        logic [10:0] fr;
        reset    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_ready", tx_ready, 1);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_dat_oe", ps2_dat_oe, 0);
        chk("rst_inhibit", rx_inhibit, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_error", tx_error, 0);
        chk("rst_err_code", err_code, 0);
        reset = 1'b1;
        @(negedge clock);

        // 0xED with ACK
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hED, 1'b0, n_inh, n_rts);
        chk("ed_inhibit_len", n_inh, INH);
        chk("ed_rts_len", n_rts, RTSC);
        dev_run(11, 1'b1, fr);
        wait_idle();
        chk("ed_start", fr[0], 0);
        chk("ed_data", fr[8:1], 8'hED);
        chk("ed_parity", fr[9], 1);
        chk("ed_stop", fr[10], 1);
        chk("ed_done_cnt", done_cnt - d0, 1);
        chk("ed_err_cnt", err_cnt - e0, 0);
        chk("ed_err_code", err_code, 0);
        chk("ed_inhibit_off", rx_inhibit, 0);

        // 0xF4 with ignored tx_valid pulses while busy
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hF4, 1'b1, n_inh, n_rts);
        chk("f4_inhibit_len", n_inh, INH);
        chk("f4_rts_len", n_rts, RTSC);
        dev_run(11, 1'b1, fr);
        wait_idle();
        chk("f4_data", fr[8:1], 8'hF4);
        chk("f4_parity", fr[9], 0);
        chk("f4_stop", fr[10], 1);
        chk("f4_done_cnt", done_cnt - d0, 1);
        chk("f4_err_code", err_code, 0);

        // no device clocking
        e0 = err_cnt;
        start_tx(8'h00, 1'b0, n_inh, n_rts);
        m = 0;
        while (!tx_error && m < STO + 1000) begin
            @(negedge clock);
            m++;
        end
        chk("sto_latency", m, STO);
        chk("sto_err_code", err_code, 1);
        chk("sto_clk_oe", ps2_clk_oe, 0);
        chk("sto_dat_oe", ps2_dat_oe, 0);
        chk("sto_ready", tx_ready, 1);
        repeat (3) @(negedge clock);
        chk("sto_err_cnt", err_cnt - e0, 1);

        // device leaves data high on the 11th clock
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hFF, 1'b0, n_inh, n_rts);
        dev_run(11, 1'b0, fr);
        wait_idle();
        chk("nack_data", fr[8:1], 8'hFF);
        chk("nack_parity", fr[9], 1);
        chk("nack_err_code", err_code, 3);
        chk("nack_err_cnt", err_cnt - e0, 1);
        chk("nack_done_cnt", done_cnt - d0, 0);

        // device stops after 4 clocks
        e0 = err_cnt;
        start_tx(8'h12, 1'b0, n_inh, n_rts);
        dev_run(4, 1'b0, fr);
        m = 0;
        while (!tx_error && m < PTO + 1000) begin
            @(negedge clock);
            m++;
        end
        chk("pto_latency", cyc - fe_cyc, PTO + 3);
        chk("pto_err_code", err_code, 2);
        chk("pto_ready", tx_ready, 1);
        repeat (3) @(negedge clock);
        chk("pto_err_cnt", err_cnt - e0, 1);

        // asynchronous reset in the middle of SEND
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h0F, 1'b0, n_inh, n_rts);
        dev_run(5, 1'b0, fr);
        @(negedge clock);
        chk("mid_dat_oe", ps2_dat_oe, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_clk_oe", ps2_clk_oe, 0);
        chk("arst_dat_oe", ps2_dat_oe, 0);
        chk("arst_ready", tx_ready, 1);
        @(negedge clock);
        reset = 1'b1;
        m = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clock);
            if (ps2_clk_oe || ps2_dat_oe || !tx_ready) m++;
        end
        chk("post_rst_quiet", m, 0);
        chk("post_rst_err_code", err_code, 0);
        chk("post_rst_done", done_cnt - d0, 0);
        chk("post_rst_err", err_cnt - e0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte per request from the FPGA to the keyboard, e.g. 0xED set LEDs, 0xFF reset, 0xF4 enable.
- Drives the shared open-drain PS2_CLK/PS2_DAT lines through active-high pull-low enables. Top level assigns line = oe ? 1'b0 : 1'bz.
- Runs alongside the existing PS/2 receive controlpath. Asserts rx_inhibit so the receiver ignores host-generated frames.

Parameters:
- INHIBIT_CYCLES, 5000: clock held low before request-to-send (100 us at 50 MHz).
- RTS_SETUP_CYCLES, 20: data held low while clock is still held low, before clock release.
- START_TIMEOUT, 750000: max cycles from clock release to the first device falling edge (15 ms).
- PACKET_TIMEOUT, 100000: max cycles from the first falling edge to ACK (2 ms).

Ports:
- clock  in  1  system clock, CLOCK_50
- reset  in  1  asynchronous, active-low reset (KEY[0])
- ps2_clk_in  in  1  sensed PS2_CLK level (asynchronous)
- ps2_dat_in  in  1  sensed PS2_DAT level (asynchronous)
- tx_data  in  8  byte to send
- tx_valid  in  1  send request
- tx_ready  out  1  high when idle and able to accept a byte
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_dat_oe  out  1  1 = pull PS2_DAT low
- rx_inhibit  out  1  high from accept until return to IDLE
- tx_done  out  1  one-cycle pulse: byte sent and ACKed
- tx_error  out  1  one-cycle pulse: transfer failed
- err_code  out  2  00 none, 01 start timeout, 10 packet timeout, 11 no ACK; held until next accept

Behaviour:
- Reset (asynchronous, active-low):
  - state IDLE; tx_ready=1; all other outputs 0; err_code=00.
  - Both oe outputs drop immediately, with no clock edge required.
- Input sync: ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer. Falling edge fe = prev_sync_clk & ~sync_clk. All decisions use synced values.
- Accept: tx_valid & tx_ready on a rising clock edge.
  - Latch tx_data and compute parity = ~^tx_data (odd parity).
  - Clear err_code; go to INHIBIT.
  - tx_ready is 0 from the next cycle. tx_valid while not ready is ignored.
- INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles, then RTS.
- RTS: clk_oe=1, dat_oe=1 (start bit) for RTS_SETUP_CYCLES cycles. Then clk_oe=0 and go to WAIT_FIRST; timer reset.
- WAIT_FIRST: dat_oe stays 1.
  - On fe: drive d0 (dat_oe = ~d0), bitcount=1, go to SEND; packet timer reset.
  - Timer reaching START_TIMEOUT without fe: error 01.
- SEND: each fe advances bitcount and drives the next bit, dat_oe = ~bit.
  - fe 2..8 carry d1..d7; fe 9 carries parity; fe 10 carries stop (dat_oe=0), then go to WAIT_ACK.
  - Data changes only on fe, the cycle fe is detected.
- WAIT_ACK: on fe 11, sample synced data.
  - 0: ACK, go to WAIT_IDLE.
  - 1: error 11.
- WAIT_IDLE: wait until synced clk=1 and data=1, then pulse tx_done and return to IDLE.
- Packet timeout: the packet timer runs through SEND, WAIT_ACK and WAIT_IDLE. Reaching PACKET_TIMEOUT gives error 10.
- Error path (any error): release both oe the same cycle, pulse tx_error, set err_code, go to IDLE.
- Simultaneous events: fe and timeout in the same cycle means fe wins.
- Timer width is $clog2(START_TIMEOUT+1). bitcount is 4 bits.

Test Plan:
- Send 0xED with a device model (clock ~12.5 kHz, ACK): wire bits after start must read 1,0,1,1,0,1,1,1; parity 1; stop 1. Then tx_done pulses once and err_code=00.
- Send 0xF4 (five ones): parity bit must be 0. clk_oe must be high exactly 5000 cycles before dat_oe rises, and dat_oe high 20 cycles before clk_oe falls.
- No device clocking: tx_error pulses START_TIMEOUT cycles after clock release, err_code=01, both oe 0, tx_ready=1.
- Device leaves data high on the 11th clock: tx_error pulses, err_code=11.
- Device stops clocking after 4 bits: tx_error pulses at PACKET_TIMEOUT, err_code=10.
- Assert reset mid-SEND: ps2_clk_oe and ps2_dat_oe drop to 0 before the next clock edge. After release, state is IDLE and tx_ready=1. tx_valid pulses while busy are ignored, and no second frame follows.
